// File: rtl/program_loader.sv
// program_loader: streams a program into ROM at sequential addresses, pads the unused tail,
// then releases the core from reset only while a complete image is present.
module program_loader #(
    parameter int ADDR = 8,
    parameter int CODE = 4,
    parameter int WORD = ADDR + CODE,
    parameter logic [WORD-1:0] PAD_WORD = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            in_valid,
    input  logic [WORD-1:0] in_word,
    input  logic            in_last,
    output logic            in_ready,
    input  logic            run_en,
    input  logic            halt,
    output logic            rom_we,
    output logic [ADDR-1:0] rom_addr,
    output logic [WORD-1:0] rom_data,
    output logic            core_run,
    output logic            busy,
    output logic            loaded,
    output logic            error,
    output logic [ADDR:0]   words_loaded
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD, READY, RUN} state_t;

    localparam logic [ADDR-1:0] TOP = '1;

    state_t          state_q, state_d;
    logic [ADDR-1:0] wp_q, wp_d;
    logic [ADDR:0]   words_q, words_d;
    logic            error_q, error_d;
    logic            loaded_q, loaded_d;
    logic            busy_q, busy_d;
    logic            run_q, run_d;
    logic            we_q, we_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic [WORD-1:0] data_q, data_d;
    logic            restart;

    assign in_ready     = state_q == LOAD;
    assign rom_we       = we_q;
    assign rom_addr     = addr_q;
    assign rom_data     = data_q;
    assign core_run     = run_q;
    assign busy         = busy_q;
    assign loaded       = loaded_q;
    assign error        = error_q;
    assign words_loaded = words_q;

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        words_d  = words_q;
        error_d  = error_q;
        loaded_d = loaded_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        // RUN ignores load_start; everywhere else it (re)starts a load and wins
        restart  = load_start && state_q != RUN;
        case (state_q)
            LOAD: if (!restart && in_valid) begin
                we_d    = 1'b1;
                addr_d  = wp_q;
                data_d  = in_word;
                wp_d    = wp_q + ADDR'(1);
                words_d = words_q + (ADDR+1)'(1);
                if (wp_q == TOP) begin
                    state_d  = READY;
                    loaded_d = 1'b1;
                    error_d  = !in_last;
                end else if (in_last) begin
                    state_d = PAD;
                end
            end
            PAD: if (!restart) begin
                we_d   = 1'b1;
                addr_d = wp_q;
                data_d = PAD_WORD;
                wp_d   = wp_q + ADDR'(1);
                if (wp_q == TOP) begin
                    state_d  = READY;
                    loaded_d = 1'b1;
                end
            end
            READY: if (!restart && run_en) state_d = RUN;
            RUN: if (halt) state_d = READY;
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d  = LOAD;
            wp_d     = '0;
            words_d  = '0;
            error_d  = 1'b0;
            loaded_d = 1'b0;
        end
        busy_d = state_d == LOAD || state_d == PAD;
        run_d  = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            words_q  <= '0;
            error_q  <= 1'b0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            run_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            words_q  <= words_d;
            error_q  <= error_d;
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
            run_q    <= run_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random program loads checked against an expected ROM write schedule.
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_word = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        run_en = 1'b0;
    logic        halt = 1'b0;
    logic        rom_we;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic        core_run;
    logic        busy;
    logic        loaded;
    logic        error;
    logic [8:0]  words_loaded;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] cyc = '0;
    logic [63:0] wq[$];

    program_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_word(in_word), .in_last(in_last), .in_ready(in_ready), .run_en(run_en),
        .halt(halt), .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_run(core_run), .busy(busy), .loaded(loaded), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;
    always @(negedge clk) if (rom_we) wq.push_back({12'd0, cyc, rom_addr, rom_data});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({in_ready, rom_we, rom_addr, rom_data, core_run, busy, loaded, error, words_loaded});
    endfunction

    task automatic load_prog(input int n, input bit last, input bit gaps, input bit fixed,
                             input int abort_at);
        logic [11:0] w[$];
        logic [31:0] hs[$];
        logic [63:0] exp[$];
        int i = 0;
        int t = 0;
        bit tog = 1'b0;
        bit v;
        for (int k = 0; k < n; k++) w.push_back(12'($urandom));
        if (fixed) w = '{12'h1A0, 12'h2B1, 12'h3C2};
        @(negedge clk) load_start = 1'b1;
        @(negedge clk) load_start = 1'b0;
        wq.delete();
        while (i < n && t < 2000) begin
            v = !gaps || tog;
            tog = !tog;
            in_valid = v;
            in_word = w[i];
            in_last = last && i == n - 1;
            if (v && in_ready) begin
                hs.push_back(cyc);
                i++;
            end
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        chk("handshakes", 64'(i), 64'(n));
        if (i < n) return;
        if (n == 256) chk("ready_after_top", 64'(in_ready), 64'd0);
        if (abort_at != 0) begin
            t = 0;
            while (!(rom_we && rom_addr == 8'(abort_at - 1)) && t < 400) begin
                @(negedge clk);
                t++;
            end
            chk("abort_reached", 64'(t < 400), 64'd1);
            rst_n = 1'b0;
            #1 chk("async_reset", outs(), 64'd0);
            @(negedge clk) rst_n = 1'b1;
            return;
        end
        t = 0;
        while (!loaded && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("loaded_timeout", 64'(t < 600), 64'd1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < n; k++) exp.push_back({12'd0, hs[k] + 32'd1, 8'(k), w[k]});
        if (last && n < 256)
            for (int a = n; a < 256; a++)
                exp.push_back({12'd0, hs[n-1] + 32'd2 + 32'(a - n), 8'(a), 12'h000});
        chk("write_count", 64'(wq.size()), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < wq.size(); k++) chk("write_cyc_addr_data", wq[k], exp[k]);
        chk("loaded", 64'(loaded), 64'd1);
        chk("busy", 64'(busy), 64'd0);
        chk("core_run", 64'(core_run), 64'd0);
        chk("words_loaded", 64'(words_loaded), 64'(n));
        chk("error", 64'(error), 64'(n == 256 && !last));
    endtask

    task automatic pulse(input bit ls, input bit re, input bit h);
        @(negedge clk);
        load_start = ls;
        run_en = re;
        halt = h;
        @(negedge clk);
        load_start = 1'b0;
        run_en = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        #1 chk("reset_outs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        chk("idle_ignores_run", 64'(core_run), 64'd0);
        load_prog(3, 1'b1, 1'b0, 1'b1, 0);
        load_prog(256, 1'b1, 1'b0, 1'b0, 0);
        load_prog(256, 1'b0, 1'b0, 1'b0, 0);
        load_prog($urandom_range(1, 40), 1'b1, 1'b1, 1'b0, 0);
        load_prog($urandom_range(41, 255), 1'b1, 1'b0, 1'b0, 0);
        chk("run_before", 64'(core_run), 64'd0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("run_next_cycle", 64'(core_run), 64'd1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("run_ignores_load", 64'({core_run, busy, loaded}), 64'b101);
        pulse(1'b0, 1'b0, 1'b1);
        chk("halt_next_cycle", 64'({core_run, loaded}), 64'b01);
        pulse(1'b0, 1'b1, 1'b0);
        chk("rerun", 64'(core_run), 64'd1);
        pulse(1'b1, 1'b0, 1'b1);
        chk("halt_beats_load", 64'({core_run, busy, loaded}), 64'b001);
        pulse(1'b1, 1'b1, 1'b0);
        chk("load_beats_run", 64'({core_run, busy, loaded, in_ready}), 64'b0101);
        load_prog($urandom_range(1, 20), 1'b1, 1'b1, 1'b0, 0);
        load_prog(5, 1'b1, 1'b0, 1'b0, 100);
        repeat (2) @(negedge clk);
        chk("after_reset_idle", 64'({loaded, busy, in_ready}), 64'd0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("after_reset_no_run", 64'(core_run), 64'd0);
        load_prog(1, 1'b1, 1'b0, 1'b0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
